mem_arbiter: RTL and testbench
==============================

MEM_ARBITER -- requirements
Module: mem_arbiter

Interface
REQ-001 Parameter MAX_HOLD, default 8: maximum consecutive locked accesses one master may hold while the other master waits.
REQ-002 Parameter FIXED_PRIO, default 0: 0 selects round-robin; 1 makes m0 always win simultaneous requests, with lock still honoured.
REQ-003 clk  in  1  single system clock; all logic on its rising edge.
REQ-004 reset  in  1  synchronous, active-high reset.
REQ-005 m0_addr / m1_addr  in  32 each  byte address of the master's request.
REQ-006 m0_wdata / m1_wdata  in  32 each  store data, already byte-lane aligned.
REQ-007 m0_wmask / m1_wmask  in  4 each  byte write enables; nonzero means a write request.
REQ-008 m0_rstrb / m1_rstrb  in  1 each  read request.
REQ-009 m0_lock / m1_lock  in  1 each  master requests to keep ownership for back-to-back accesses.
REQ-010 m0_ack / m1_ack  out  1 each  request accepted and issued this cycle.
REQ-011 m0_rvalid / m1_rvalid  out  1 each  read data valid, exactly one cycle after the accepting ack.
REQ-012 m0_rdata / m1_rdata  out  32 each  read data, driven equal to mem_rdata.
REQ-013 mem_addr  out  32  address to the shared memory.
REQ-014 mem_wdata  out  32  store data to the shared memory.
REQ-015 mem_wmask  out  4  write enables to the shared memory.
REQ-016 mem_rstrb  out  1  read strobe to the shared memory.
REQ-017 mem_rdata  in  32  memory read data, valid one cycle after mem_rstrb.

Function
REQ-018 A master's request SHALL be defined as rstrb OR (wmask != 0); a master asserting both rstrb and a nonzero wmask SHALL be issued as a single access carrying both.
REQ-019 Once raised, a request and all its fields SHALL stay stable until the cycle of its ack, inclusive.
REQ-020 At most one access SHALL be issued per cycle, and it SHALL be issued in the same cycle as its ack.
REQ-021 The issued master's addr, wdata, wmask and rstrb SHALL drive the mem_* outputs combinationally.
REQ-022 In a cycle with no ack, mem_wmask SHALL be 0 and mem_rstrb SHALL be 0; mem_addr is don't-care.
REQ-023 The FSM SHALL have states IDLE, OWN0 and OWN1, recording which master was issued in the previous cycle (IDLE = none).
REQ-024 With a single requester, that requester SHALL be acked in the same cycle, from any state.
REQ-025 With both requesting, the winner SHALL be chosen as follows: if the current owner has lock set and hold_cnt < MAX_HOLD, the owner wins; otherwise, with FIXED_PRIO=0 the master not acked most recently wins, and with FIXED_PRIO=1 m0 wins.
REQ-026 hold_cnt SHALL count consecutive acks to the same master.
REQ-027 hold_cnt SHALL reset to 1 when ownership changes, and SHALL saturate at MAX_HOLD.
REQ-028 When a master is forced off at MAX_HOLD, the other master SHALL receive exactly one access before the locked master can regain ownership.
REQ-029 Rule 028 does not apply if the other master has no request in that cycle.
REQ-030 A read ack SHALL set the matching rvalid on the next cycle only; writes never assert rvalid.
REQ-031 Back-to-back reads by alternating masters SHALL each return their rvalid in their own cycle, with no data swap.
REQ-032 A write followed next cycle by a read of the same address SHALL return the new data, since ordering is issue order.
REQ-033 The last-acked pointer SHALL update on every ack; IDLE cycles SHALL leave the pointer and hold_cnt unchanged.

Reset
REQ-034 While reset is high: all ack, rvalid and mem_rstrb outputs 0; mem_wmask 0; state IDLE; hold_cnt 0; last-acked pointer = m1, so m0 wins the first contention.
REQ-035 A read acked in the cycle before reset asserts SHALL NOT produce rvalid while reset is high.
REQ-036 No access SHALL be issued in the cycle reset is high, even if requests are present.

Structure
REQ-037 A shared package SHALL hold the FSM state encodings (IDLE=0, OWN0=1, OWN1=2), the master index constants, and the MAX_HOLD default.
REQ-038 The grant-selection logic SHALL be one sub-module, rr_arbiter2: inputs req[1:0], lock, hold_expired and last_grant; output a one-hot grant.
REQ-039 rr_arbiter2 SHALL be purely combinational; mem_arbiter SHALL hold the state, counters and rvalid registers.

Verification
REQ-040 Scenario 1: after reset, m0 read 0x100 and m1 read 0x200 raised in the same cycle -> m0_ack in cycle 1, m1_ack in cycle 2; m0_rvalid in cycle 2 and m1_rvalid in cycle 3, each carrying its own word.
REQ-041 Scenario 2: both masters continuously requesting, locks low, FIXED_PRIO=0 -> acks alternate m0, m1, m0, m1 with no gaps.
REQ-042 Scenario 3: m1_lock high, m1 issuing 12 writes, m0 requesting from the first cycle -> m1 acked 8 times, m0 acked once, then m1 resumes.
REQ-043 Scenario 4: m0 writes 0xDEADBEEF with wmask 0011 to 0x40, then m1 reads 0x40 -> returned low half 0xBEEF, upper half unchanged.
REQ-044 Scenario 5: reset asserted the cycle after m0's read ack -> m0_rvalid stays 0; afterwards the FSM is IDLE and m0 wins the next contention.
REQ-045 Scenario 6: FIXED_PRIO=1, both masters continuously requesting -> m1 is never acked until m0 drops its request.

Source files
------------

// File: rtl/mem_arbiter_pkg.sv
// -----------------------------------------------------------------------------
// mem_arbiter_pkg
// Shared definitions for the two-master memory arbiter:
//   - arb_state_e      : which master was issued an access in the previous cycle
//   - MASTER0/MASTER1  : master index constants (also the last-grant encoding)
//   - MAX_HOLD_DEFAULT : default cap on consecutive locked accesses
//   - master_onehot()  : converts a master index into a one-hot grant vector
// -----------------------------------------------------------------------------
package mem_arbiter_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        OWN0 = 2'd1,
        OWN1 = 2'd2
    } arb_state_e;

    localparam logic MASTER0 = 1'b0;
    localparam logic MASTER1 = 1'b1;

    localparam int MAX_HOLD_DEFAULT = 8;

    function automatic logic [1:0] master_onehot(input logic master);
        return master ? 2'b10 : 2'b01;
    endfunction

endpackage

// File: rtl/rr_arbiter2.sv
// -----------------------------------------------------------------------------
// rr_arbiter2
// Purely combinational grant selection between two masters.
// Ports:
//   req          in  2  request per master (bit 0 = m0, bit 1 = m1)
//   lock         in  1  the current owner (the master issued last cycle) holds lock
//   hold_expired in  1  the owner has used up its consecutive-access allowance
//   last_grant   in  1  index of the master acked most recently
//   grant        out 2  one-hot grant, zero when nobody requests
// Parameter FIXED_PRIO: 0 = round-robin, 1 = m0 wins unlocked contention.
// -----------------------------------------------------------------------------
module rr_arbiter2
    import mem_arbiter_pkg::*;
#(
    parameter int FIXED_PRIO = 0
) (
    input  logic [1:0] req,
    input  logic       lock,
    input  logic       hold_expired,
    input  logic       last_grant,
    output logic [1:0] grant
);

    // A lone requester is always served. Under contention a locked owner keeps
    // the bus until its allowance runs out; at that point the other master is
    // forced in for one access regardless of FIXED_PRIO, so that a locked m0
    // cannot starve m1 in fixed-priority mode.
    always_comb begin
        grant = 2'b00;
        unique case (req)
            2'b01: grant = 2'b01;
            2'b10: grant = 2'b10;
            2'b11: begin
                if (lock && !hold_expired) begin
                    grant = master_onehot(last_grant);
                end else if (lock) begin
                    grant = master_onehot(~last_grant);
                end else if (FIXED_PRIO != 0) begin
                    grant = master_onehot(MASTER0);
                end else begin
                    grant = master_onehot(~last_grant);
                end
            end
            default: grant = 2'b00;
        endcase
    end

endmodule

// File: rtl/mem_arbiter.sv
// -----------------------------------------------------------------------------
// mem_arbiter
// Two-master arbiter in front of a single-port shared memory. One access is
// issued per cycle, in the same cycle as its ack; the winning master's fields
// drive mem_* combinationally. Read data returns one cycle after issue and is
// flagged with the matching rvalid.
// Ports:
//   clk, reset                      clock, synchronous active-high reset
//   mN_addr/wdata/wmask/rstrb/lock  master N request (request = rstrb | |wmask)
//   mN_ack                          master N issued this cycle
//   mN_rvalid/rdata                 master N read data, one cycle after ack
//   mem_addr/wdata/wmask/rstrb      access to shared memory
//   mem_rdata                       memory read data, one cycle after mem_rstrb
// Parameters: MAX_HOLD (locked access cap), FIXED_PRIO (0 RR, 1 m0 first).
// -----------------------------------------------------------------------------
module mem_arbiter
    import mem_arbiter_pkg::*;
#(
    parameter int MAX_HOLD   = MAX_HOLD_DEFAULT,
    parameter int FIXED_PRIO = 0
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [31:0] m0_addr,
    input  logic [31:0] m0_wdata,
    input  logic [3:0]  m0_wmask,
    input  logic        m0_rstrb,
    input  logic        m0_lock,
    output logic        m0_ack,
    output logic        m0_rvalid,
    output logic [31:0] m0_rdata,
    input  logic [31:0] m1_addr,
    input  logic [31:0] m1_wdata,
    input  logic [3:0]  m1_wmask,
    input  logic        m1_rstrb,
    input  logic        m1_lock,
    output logic        m1_ack,
    output logic        m1_rvalid,
    output logic [31:0] m1_rdata,
    output logic [31:0] mem_addr,
    output logic [31:0] mem_wdata,
    output logic [3:0]  mem_wmask,
    output logic        mem_rstrb,
    input  logic [31:0] mem_rdata
);

    localparam int HOLD_W = $clog2(MAX_HOLD + 1);
    localparam logic [HOLD_W-1:0] HOLD_LIMIT = HOLD_W'(MAX_HOLD);

    arb_state_e        state;
    arb_state_e        state_next;
    logic [HOLD_W-1:0] hold_cnt;
    logic [HOLD_W-1:0] hold_next;
    logic              last_grant;
    logic              last_next;
    logic [1:0]        rvalid_q;
    logic [1:0]        req;
    logic              owner_lock;
    logic              hold_expired;
    logic [1:0]        grant_raw;
    logic [1:0]        grant;

    assign req = {m1_rstrb | (|m1_wmask), m0_rstrb | (|m0_wmask)};

    // Only a master issued in the previous cycle counts as owner; after an
    // idle cycle nobody holds the lock.
    always_comb begin
        owner_lock = 1'b0;
        unique case (state)
            OWN0:    owner_lock = m0_lock;
            OWN1:    owner_lock = m1_lock;
            default: owner_lock = 1'b0;
        endcase
    end

    assign hold_expired = (hold_cnt >= HOLD_LIMIT);

    rr_arbiter2 #(
        .FIXED_PRIO(FIXED_PRIO)
    ) u_rr_arbiter2 (
        .req         (req),
        .lock        (owner_lock),
        .hold_expired(hold_expired),
        .last_grant  (last_grant),
        .grant       (grant_raw)
    );

    // Nothing is issued while reset is high, even with requests pending.
    assign grant  = reset ? 2'b00 : grant_raw;
    assign m0_ack = grant[0];
    assign m1_ack = grant[1];

    // Steer the winner onto the memory port; with no grant the strobes are
    // forced low and the address simply follows m0.
    always_comb begin
        mem_addr  = m0_addr;
        mem_wdata = m0_wdata;
        mem_wmask = 4'b0000;
        mem_rstrb = 1'b0;
        if (grant[1]) begin
            mem_addr  = m1_addr;
            mem_wdata = m1_wdata;
            mem_wmask = m1_wmask;
            mem_rstrb = m1_rstrb;
        end else if (grant[0]) begin
            mem_addr  = m0_addr;
            mem_wdata = m0_wdata;
            mem_wmask = m0_wmask;
            mem_rstrb = m0_rstrb;
        end
    end

    // Next-state logic. The hold counter restarts at 1 on a change of master
    // and saturates at MAX_HOLD; idle cycles keep both pointer and counter.
    always_comb begin
        state_next = IDLE;
        hold_next  = hold_cnt;
        last_next  = last_grant;
        if (grant[0] || grant[1]) begin
            state_next = grant[1] ? OWN1 : OWN0;
            last_next  = grant[1] ? MASTER1 : MASTER0;
            if (last_next == last_grant) begin
                hold_next = (hold_cnt == HOLD_LIMIT) ? hold_cnt : hold_cnt + 1'b1;
            end else begin
                hold_next = HOLD_W'(1);
            end
        end
    end

    // Pointer resets to m1 so that m0 wins the first contention.
    always_ff @(posedge clk) begin
        if (reset) begin
            state      <= IDLE;
            hold_cnt   <= '0;
            last_grant <= MASTER1;
            rvalid_q   <= 2'b00;
        end else begin
            state      <= state_next;
            hold_cnt   <= hold_next;
            last_grant <= last_next;
            rvalid_q   <= {grant[1] & m1_rstrb, grant[0] & m0_rstrb};
        end
    end

    // rvalid is masked during reset so a read acked just before reset never
    // shows up while reset is high.
    assign m0_rvalid = rvalid_q[0] & ~reset;
    assign m1_rvalid = rvalid_q[1] & ~reset;
    assign m0_rdata  = mem_rdata;
    assign m1_rdata  = mem_rdata;

endmodule

// File: tb/tb_mem_arbiter.sv
// -----------------------------------------------------------------------------
// tb_mem_arbiter
// Self-checking bench for mem_arbiter. A behavioural memory answers the
// arbiter's memory port; a reference model built from the ack history and a
// reference copy of memory predicts acks, memory-port fields, rvalid and data.
// A second instance with FIXED_PRIO=1 is exercised with a directed sequence.
// -----------------------------------------------------------------------------
module tb_mem_arbiter;

    localparam int MAX_HOLD = 8;

    typedef struct {
        bit          active;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [3:0]  wmask;
        bit          rstrb;
        bit          lock;
    } req_t;

    logic        clk = 1'b0;
    logic        reset;
    logic [31:0] m0_addr, m0_wdata, m1_addr, m1_wdata;
    logic [3:0]  m0_wmask, m1_wmask;
    logic        m0_rstrb, m0_lock, m1_rstrb, m1_lock;
    logic        m0_ack, m0_rvalid, m1_ack, m1_rvalid;
    logic [31:0] m0_rdata, m1_rdata;
    logic [31:0] mem_addr, mem_wdata, mem_rdata;
    logic [3:0]  mem_wmask;
    logic        mem_rstrb;

    logic        fp_m0_rstrb, fp_m1_rstrb;
    logic        fp_m0_ack, fp_m0_rvalid, fp_m1_ack, fp_m1_rvalid;
    logic [31:0] fp_m0_rdata, fp_m1_rdata, fp_mem_addr, fp_mem_wdata;
    logic [3:0]  fp_mem_wmask;
    logic        fp_mem_rstrb;

    always #5 clk = ~clk;

    mem_arbiter #(.MAX_HOLD(MAX_HOLD), .FIXED_PRIO(0)) dut (
        .clk(clk), .reset(reset),
        .m0_addr(m0_addr), .m0_wdata(m0_wdata), .m0_wmask(m0_wmask),
        .m0_rstrb(m0_rstrb), .m0_lock(m0_lock), .m0_ack(m0_ack),
        .m0_rvalid(m0_rvalid), .m0_rdata(m0_rdata),
        .m1_addr(m1_addr), .m1_wdata(m1_wdata), .m1_wmask(m1_wmask),
        .m1_rstrb(m1_rstrb), .m1_lock(m1_lock), .m1_ack(m1_ack),
        .m1_rvalid(m1_rvalid), .m1_rdata(m1_rdata),
        .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_wmask(mem_wmask),
        .mem_rstrb(mem_rstrb), .mem_rdata(mem_rdata)
    );

    mem_arbiter #(.MAX_HOLD(MAX_HOLD), .FIXED_PRIO(1)) dut_fp (
        .clk(clk), .reset(reset),
        .m0_addr(32'h0000_0010), .m0_wdata(32'h0), .m0_wmask(4'h0),
        .m0_rstrb(fp_m0_rstrb), .m0_lock(1'b0), .m0_ack(fp_m0_ack),
        .m0_rvalid(fp_m0_rvalid), .m0_rdata(fp_m0_rdata),
        .m1_addr(32'h0000_0020), .m1_wdata(32'h0), .m1_wmask(4'h0),
        .m1_rstrb(fp_m1_rstrb), .m1_lock(1'b0), .m1_ack(fp_m1_ack),
        .m1_rvalid(fp_m1_rvalid), .m1_rdata(fp_m1_rdata),
        .mem_addr(fp_mem_addr), .mem_wdata(fp_mem_wdata), .mem_wmask(fp_mem_wmask),
        .mem_rstrb(fp_mem_rstrb), .mem_rdata(32'h0)
    );

    // Behavioural memory: read returns the word as it was before any write in
    // the same access, one cycle after the strobe.
    logic [31:0] dev_mem [256];
    always @(posedge clk) begin
        if (mem_rstrb) mem_rdata <= dev_mem[mem_addr[9:2]];
        for (int b = 0; b < 4; b++)
            if (mem_wmask[b]) dev_mem[mem_addr[9:2]][8*b +: 8] = mem_wdata[8*b +: 8];
    end

    // Reference model state
    logic [31:0] ref_mem [256];
    int          hist[$];
    bit          prev_acked;
    bit          exp_rv [2];
    logic [31:0] exp_rd [2];
    logic [31:0] last_rd [2];
    req_t        pend [2];
    int          mode;
    bit          rst_drive;
    int          streak, max_streak;
    int          checks = 0;
    int          errors = 0;

    function automatic logic [31:0] initWord(input int i);
        return 32'hC0DE_0000 + 32'(i) * 32'h0001_0001;
    endfunction

    task automatic checkOutput(input string tag, input logic [31:0] observed,
                               input logic [31:0] expected);
        checks++;
        if (observed !== expected) begin
            errors++;
            $display("[TB] FAIL %s observed=%h expected=%h at %0t", tag, observed, expected, $time);
        end
    endtask

    // Length of the current run of acks to the same master, capped at MAX_HOLD.
    function automatic int trailingRun();
        int n = 0;
        if (hist.size() == 0) return 0;
        for (int i = hist.size() - 1; i >= 0; i--) begin
            if (hist[i] == hist[hist.size()-1]) n++;
            else break;
        end
        return (n > MAX_HOLD) ? MAX_HOLD : n;
    endfunction

    function automatic int expectedGrant(input bit r0, input bit r1, input bit l0, input bit l1);
        int last = (hist.size() == 0) ? 1 : hist[hist.size()-1];
        if (!r0 && !r1) return -1;
        if (r0 && !r1) return 0;
        if (r1 && !r0) return 1;
        if (prev_acked && ((last == 0) ? l0 : l1)) begin
            if (trailingRun() < MAX_HOLD) return last;
            return 1 - last;
        end
        return 1 - last;
    endfunction

    function automatic req_t randomReq(input int kind, input bit lk);
        req_t r;
        r.active = 1'b1;
        r.addr   = {22'd0, 8'($urandom_range(0, 255)), 2'b00};
        r.wdata  = $urandom();
        r.lock   = lk;
        case (kind)
            0: begin r.rstrb = 1'b1; r.wmask = 4'h0; end
            1: begin r.rstrb = 1'b0; r.wmask = 4'($urandom_range(1, 15)); end
            default: begin
                r.wmask = 4'($urandom_range(0, 15));
                r.rstrb = (r.wmask == 4'h0) ? 1'b1 : 1'($urandom_range(0, 1));
            end
        endcase
        return r;
    endfunction

    task automatic queueReq(input int m, input logic [31:0] a, input logic [31:0] d,
                            input logic [3:0] wm, input bit rs);
        pend[m].active = 1'b1; pend[m].addr = a; pend[m].wdata = d;
        pend[m].wmask = wm; pend[m].rstrb = rs; pend[m].lock = 1'b0;
    endtask

    // Refill free masters according to the current mode and drive the pins;
    // a pending request is held unchanged until it is acked.
    task automatic applyStimulus();
        reset = rst_drive | ((mode == 1) && ($urandom_range(0, 49) == 0));
        for (int m = 0; m < 2; m++) begin
            if (!pend[m].active) begin
                case (mode)
                    1: if ($urandom_range(0, 1) == 1)
                           pend[m] = randomReq(2, $urandom_range(0, 3) == 0);
                    2: pend[m] = randomReq(2, 1'b0);
                    3: pend[m] = (m == 1) ? randomReq(1, 1'b1) : randomReq(0, 1'b0);
                    default: ;
                endcase
            end
        end
        m0_addr  = pend[0].active ? pend[0].addr  : $urandom();
        m0_wdata = pend[0].active ? pend[0].wdata : $urandom();
        m0_wmask = pend[0].active ? pend[0].wmask : 4'h0;
        m0_rstrb = pend[0].active ? pend[0].rstrb : 1'b0;
        m0_lock  = pend[0].active ? pend[0].lock  : 1'b0;
        m1_addr  = pend[1].active ? pend[1].addr  : $urandom();
        m1_wdata = pend[1].active ? pend[1].wdata : $urandom();
        m1_wmask = pend[1].active ? pend[1].wmask : 4'h0;
        m1_rstrb = pend[1].active ? pend[1].rstrb : 1'b0;
        m1_lock  = pend[1].active ? pend[1].lock  : 1'b0;
    endtask

    task automatic runCycle();
        int   g;
        int   idx;
        req_t cur;
        @(negedge clk);
        applyStimulus();
        #1;
        g = reset ? -1 : expectedGrant(pend[0].active, pend[1].active, pend[0].lock, pend[1].lock);
        checkOutput("m0_ack", 32'(m0_ack), 32'(g == 0));
        checkOutput("m1_ack", 32'(m1_ack), 32'(g == 1));
        checkOutput("m0_rvalid", 32'(m0_rvalid), 32'(exp_rv[0] && !reset));
        checkOutput("m1_rvalid", 32'(m1_rvalid), 32'(exp_rv[1] && !reset));
        if (exp_rv[0] && !reset) begin
            checkOutput("m0_rdata", m0_rdata, exp_rd[0]);
            last_rd[0] = m0_rdata;
        end
        if (exp_rv[1] && !reset) begin
            checkOutput("m1_rdata", m1_rdata, exp_rd[1]);
            last_rd[1] = m1_rdata;
        end
        if (m1_ack && !m0_ack) begin
            streak++;
            if (streak > max_streak) max_streak = streak;
        end else if (m0_ack) begin
            streak = 0;
        end
        exp_rv[0] = 1'b0;
        exp_rv[1] = 1'b0;
        if (g >= 0) begin
            cur = pend[g];
            checkOutput("mem_rstrb", 32'(mem_rstrb), 32'(cur.rstrb));
            checkOutput("mem_wmask", 32'(mem_wmask), 32'(cur.wmask));
            checkOutput("mem_addr", mem_addr, cur.addr);
            if (cur.wmask != 4'h0) checkOutput("mem_wdata", mem_wdata, cur.wdata);
            idx = int'(cur.addr[9:2]);
            if (cur.rstrb) begin
                exp_rv[g] = 1'b1;
                exp_rd[g] = ref_mem[idx];
            end
            for (int b = 0; b < 4; b++)
                if (cur.wmask[b]) ref_mem[idx][8*b +: 8] = cur.wdata[8*b +: 8];
            hist.push_back(g);
            if (hist.size() > 2 * MAX_HOLD) void'(hist.pop_front());
            prev_acked = 1'b1;
            pend[g].active = 1'b0;
        end else begin
            checkOutput("mem_rstrb_idle", 32'(mem_rstrb), 32'h0);
            checkOutput("mem_wmask_idle", 32'(mem_wmask), 32'h0);
            prev_acked = 1'b0;
            if (reset) hist.delete();
        end
    endtask

    task automatic waitAck(input int m);
        int n = 0;
        while (pend[m].active && n < 20) begin
            runCycle();
            n++;
        end
        if (pend[m].active) begin
            checkOutput("ack_timeout", 32'h0, 32'h1);
            pend[m].active = 1'b0;
        end
    endtask

    task automatic drainAll();
        mode = 0;
        waitAck(0);
        waitAck(1);
        runCycle();
    endtask

    initial begin
        for (int i = 0; i < 256; i++) begin
            dev_mem[i] = initWord(i);
            ref_mem[i] = initWord(i);
        end
        pend[0].active = 1'b0;
        pend[1].active = 1'b0;
        exp_rv[0] = 1'b0;
        exp_rv[1] = 1'b0;
        prev_acked = 1'b0;
        streak = 0;
        max_streak = 0;
        mode = 0;
        rst_drive = 1'b1;
        fp_m0_rstrb = 1'b0;
        fp_m1_rstrb = 1'b0;
        reset = 1'b1;

        // Reset with requests already present: nothing may be issued.
        runCycle();
        queueReq(0, 32'h100, 32'h0, 4'h0, 1'b1);
        queueReq(1, 32'h200, 32'h0, 4'h0, 1'b1);
        runCycle();
        rst_drive = 1'b0;
        $display("[TB] scenario 1: simultaneous reads after reset");
        runCycle();
        runCycle();
        runCycle();

        $display("[TB] scenario 4: partial write then read of same word");
        queueReq(0, 32'h40, 32'hDEAD_BEEF, 4'b0011, 1'b0);
        waitAck(0);
        queueReq(1, 32'h40, 32'h0, 4'h0, 1'b1);
        waitAck(1);
        runCycle();
        checkOutput("s4_word", last_rd[1], 32'hC0EE_BEEF);

        $display("[TB] scenario 5: reset right after a read ack");
        queueReq(0, 32'h80, 32'h0, 4'h0, 1'b1);
        waitAck(0);
        rst_drive = 1'b1;
        runCycle();
        rst_drive = 1'b0;
        queueReq(0, 32'h84, 32'h0, 4'h0, 1'b1);
        queueReq(1, 32'h88, 32'h0, 4'h0, 1'b1);
        runCycle();
        checkOutput("s5_m0_wins", 32'(m0_ack), 32'h1);
        drainAll();

        $display("[TB] scenario 2: continuous contention, no locks");
        mode = 2;
        repeat (16) runCycle();
        drainAll();

        $display("[TB] scenario 3: locked writer against a waiting reader");
        queueReq(0, 32'h10, 32'h0, 4'h0, 1'b1);
        waitAck(0);
        streak = 0;
        max_streak = 0;
        mode = 3;
        repeat (30) runCycle();
        drainAll();
        checkOutput("s3_max_m1_run", 32'(max_streak), 32'(MAX_HOLD));

        $display("[TB] random traffic");
        mode = 1;
        repeat (2000) runCycle();
        rst_drive = 1'b0;
        drainAll();

        $display("[TB] scenario 6: fixed priority instance");
        @(negedge clk);
        fp_m0_rstrb = 1'b1;
        fp_m1_rstrb = 1'b1;
        for (int c = 0; c < 10; c++) begin
            #1;
            checkOutput("fp_m0_ack", 32'(fp_m0_ack), 32'h1);
            checkOutput("fp_m1_ack", 32'(fp_m1_ack), 32'h0);
            @(negedge clk);
        end
        fp_m0_rstrb = 1'b0;
        #1;
        checkOutput("fp_m1_after_drop", 32'(fp_m1_ack), 32'h1);
        @(negedge clk);
        fp_m1_rstrb = 1'b0;

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #1_000_000;
        $display("[TB] FAIL watchdog observed=timeout expected=finish");
        errors++;
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
